// File: rtl/rvh_l1d_req_arb_dec.sv
// L1D request front-end: round-robin pick among load, store/AMO and PTW
// sources, opcode decode into a one-hot class bundle, registered output.
module rvh_l1d_req_arb_dec #(
  parameter int N_LD  = 2,
  parameter int N_ST  = 1,
  parameter int TAG_W = 8,
  localparam int NSRC  = N_LD + N_ST + 1,
  localparam int SRC_W = (NSRC > 2) ? $clog2(NSRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic [N_LD-1:0]         ld_req_vld_i,
  input  logic [N_LD*3-1:0]       ld_req_opcode_i,
  input  logic [N_LD*TAG_W-1:0]   ld_req_tag_i,
  output logic [N_LD-1:0]         ld_req_rdy_o,
  input  logic [N_ST-1:0]         st_req_vld_i,
  input  logic [N_ST*5-1:0]       st_req_opcode_i,
  input  logic [N_ST*TAG_W-1:0]   st_req_tag_i,
  output logic [N_ST-1:0]         st_req_rdy_o,
  input  logic                    ptw_req_vld_i,
  input  logic [TAG_W-1:0]        ptw_req_tag_i,
  output logic                    ptw_req_rdy_o,
  output logic                    dec_vld_o,
  input  logic                    dec_rdy_i,
  output logic [SRC_W-1:0]        dec_src_o,
  output logic [TAG_W-1:0]        dec_tag_o,
  output logic                    dec_is_ld_o,
  output logic                    dec_is_st_o,
  output logic                    dec_is_ptw_o,
  output logic                    dec_is_lr_o,
  output logic                    dec_is_sc_o,
  output logic                    dec_is_amo_o,
  output logic [2:0]              dec_amo_op_o,
  output logic                    dec_unsigned_o,
  output logic [1:0]              dec_size_o,
  output logic                    dec_illegal_o
);

  typedef struct packed {
    logic       is_ld;
    logic       is_st;
    logic       is_ptw;
    logic       is_lr;
    logic       is_sc;
    logic       is_amo;
    logic [2:0] amo_op;
    logic       uns;
    logic [1:0] size;
    logic       illegal;
  } dec_t;

  function automatic dec_t dec_ld(input logic [2:0] op);
    dec_t d;
    d = '0;
    unique case (op)
      3'd0: begin d.is_ld = 1'b1; d.size = 2'd0; end
      3'd1: begin d.is_ld = 1'b1; d.size = 2'd1; end
      3'd2: begin d.is_ld = 1'b1; d.size = 2'd2; end
      3'd3: begin d.is_ld = 1'b1; d.size = 2'd0; d.uns = 1'b1; end
      3'd4: begin d.is_ld = 1'b1; d.size = 2'd1; d.uns = 1'b1; end
      3'd5: begin d.is_ld = 1'b1; d.size = 2'd2; d.uns = 1'b1; end
      3'd6: begin d.is_ld = 1'b1; d.size = 2'd3; end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  function automatic dec_t dec_st(input logic [4:0] op);
    dec_t       d;
    logic [4:0] k;
    d = '0;
    // AMO pairs: k indexes SWAP..MINU, odd opcode is .W
    k = (op - 5'd11) >> 1;
    unique case (1'b1)
      (op <= 5'd3): begin
        d.is_st = 1'b1;
        d.size  = op[1:0];
      end
      (op == 5'd7 || op == 5'd8): begin
        d.is_lr = 1'b1;
        d.size  = op[0] ? 2'd2 : 2'd3;
      end
      (op == 5'd9 || op == 5'd10): begin
        d.is_sc = 1'b1;
        d.size  = op[0] ? 2'd2 : 2'd3;
      end
      (op >= 5'd11 && op <= 5'd28): begin
        d.is_amo = 1'b1;
        d.size   = op[0] ? 2'd2 : 2'd3;
        d.uns    = (k == 5'd6) || (k == 5'd8);
        unique case (k)
          5'd0, 5'd1, 5'd2, 5'd3, 5'd4: d.amo_op = k[2:0];
          5'd5, 5'd6: d.amo_op = 3'd5;
          default:    d.amo_op = 3'd6;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  logic [NSRC-1:0]  src_vld;
  logic [NSRC-1:0]  gnt_oh;
  logic [NSRC-1:0]  rdy_vec;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W-1:0] rr_ptr;
  logic             gnt_any;
  logic             can_accept;
  logic             acc;
  dec_t             win;
  logic [TAG_W-1:0] win_tag;
  dec_t             dec_q;
  logic [SRC_W-1:0] src_q;
  logic [TAG_W-1:0] tag_q;
  logic             vld_q;

  assign src_vld = {ptw_req_vld_i, st_req_vld_i, ld_req_vld_i};

  always_comb begin
    int j;
    j       = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      j = (int'(rr_ptr) + i) % NSRC;
      if (!gnt_any && src_vld[j]) begin
        gnt_any    = 1'b1;
        gnt_oh[j]  = 1'b1;
        gnt_idx    = SRC_W'(j);
      end
    end
  end

  assign can_accept    = (~vld_q | dec_rdy_i) & ~flush_i & ~rst;
  assign rdy_vec       = gnt_oh & {NSRC{can_accept}};
  assign acc           = |rdy_vec;
  assign ld_req_rdy_o  = rdy_vec[N_LD-1:0];
  assign st_req_rdy_o  = rdy_vec[N_LD +: N_ST];
  assign ptw_req_rdy_o = rdy_vec[NSRC-1];

  always_comb begin
    int s;
    s       = int'(gnt_idx) - N_LD;
    win     = '0;
    win_tag = '0;
    if (int'(gnt_idx) < N_LD) begin
      win     = dec_ld(ld_req_opcode_i[3*gnt_idx +: 3]);
      win_tag = ld_req_tag_i[TAG_W*gnt_idx +: TAG_W];
    end else if (int'(gnt_idx) < N_LD + N_ST) begin
      win     = dec_st(st_req_opcode_i[5*s +: 5]);
      win_tag = st_req_tag_i[TAG_W*s +: TAG_W];
    end else begin
      win.is_ptw = 1'b1;
      win.size   = 2'd3;
      win_tag    = ptw_req_tag_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dec_q  <= '0;
      src_q  <= '0;
      tag_q  <= '0;
      rr_ptr <= '0;
    end else if (acc) begin
      vld_q  <= 1'b1;
      dec_q  <= win;
      src_q  <= gnt_idx;
      tag_q  <= win_tag;
      rr_ptr <= (int'(gnt_idx) == NSRC - 1) ? '0 : gnt_idx + 1'b1;
    end else if (flush_i | dec_rdy_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign dec_vld_o      = vld_q;
  assign dec_src_o      = src_q;
  assign dec_tag_o      = tag_q;
  assign dec_is_ld_o    = dec_q.is_ld;
  assign dec_is_st_o    = dec_q.is_st;
  assign dec_is_ptw_o   = dec_q.is_ptw;
  assign dec_is_lr_o    = dec_q.is_lr;
  assign dec_is_sc_o    = dec_q.is_sc;
  assign dec_is_amo_o   = dec_q.is_amo;
  assign dec_amo_op_o   = dec_q.amo_op;
  assign dec_unsigned_o = dec_q.uns;
  assign dec_size_o     = dec_q.size;
  assign dec_illegal_o  = dec_q.illegal;

endmodule

// File: tb/tb_rvh_l1d_req_arb_dec.sv
// Directed bench for rvh_l1d_req_arb_dec with N_LD=2, N_ST=1, TAG_W=8.
module tb_rvh_l1d_req_arb_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_i;
  logic [1:0] ld_req_vld_i;
  logic [5:0] ld_req_opcode_i;
  logic [15:0] ld_req_tag_i;
  logic [1:0] ld_req_rdy_o;
  logic [0:0] st_req_vld_i;
  logic [4:0] st_req_opcode_i;
  logic [7:0] st_req_tag_i;
  logic [0:0] st_req_rdy_o;
  logic       ptw_req_vld_i;
  logic [7:0] ptw_req_tag_i;
  logic       ptw_req_rdy_o;
  logic       dec_vld_o;
  logic       dec_rdy_i;
  logic [1:0] dec_src_o;
  logic [7:0] dec_tag_o;
  logic       dec_is_ld_o, dec_is_st_o, dec_is_ptw_o;
  logic       dec_is_lr_o, dec_is_sc_o, dec_is_amo_o;
  logic [2:0] dec_amo_op_o;
  logic       dec_unsigned_o;
  logic [1:0] dec_size_o;
  logic       dec_illegal_o;

  int total = 0;
  int fails = 0;

  wire [5:0] cls = {dec_is_ld_o, dec_is_st_o, dec_is_ptw_o,
                    dec_is_lr_o, dec_is_sc_o, dec_is_amo_o};
  wire [3:0] rdy_all = {ptw_req_rdy_o, st_req_rdy_o, ld_req_rdy_o};

  always #5 clk = ~clk;

  rvh_l1d_req_arb_dec #(.N_LD(2), .N_ST(1), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .ld_req_vld_i(ld_req_vld_i), .ld_req_opcode_i(ld_req_opcode_i),
    .ld_req_tag_i(ld_req_tag_i), .ld_req_rdy_o(ld_req_rdy_o),
    .st_req_vld_i(st_req_vld_i), .st_req_opcode_i(st_req_opcode_i),
    .st_req_tag_i(st_req_tag_i), .st_req_rdy_o(st_req_rdy_o),
    .ptw_req_vld_i(ptw_req_vld_i), .ptw_req_tag_i(ptw_req_tag_i),
    .ptw_req_rdy_o(ptw_req_rdy_o),
    .dec_vld_o(dec_vld_o), .dec_rdy_i(dec_rdy_i),
    .dec_src_o(dec_src_o), .dec_tag_o(dec_tag_o),
    .dec_is_ld_o(dec_is_ld_o), .dec_is_st_o(dec_is_st_o),
    .dec_is_ptw_o(dec_is_ptw_o), .dec_is_lr_o(dec_is_lr_o),
    .dec_is_sc_o(dec_is_sc_o), .dec_is_amo_o(dec_is_amo_o),
    .dec_amo_op_o(dec_amo_op_o), .dec_unsigned_o(dec_unsigned_o),
    .dec_size_o(dec_size_o), .dec_illegal_o(dec_illegal_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int order [5] = '{1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1; flush_i = 1'b0; dec_rdy_i = 1'b1;
    ld_req_vld_i = 2'b11; ld_req_opcode_i = '0; ld_req_tag_i = '0;
    st_req_vld_i = 1'b0; st_req_opcode_i = '0; st_req_tag_i = '0;
    ptw_req_vld_i = 1'b0; ptw_req_tag_i = '0;
    tick(); tick(); #1;
    chk("rst_vld", 32'(dec_vld_o), 0);
    chk("rst_rdy", 32'(rdy_all), 0);
    chk("rst_src", 32'(dec_src_o), 0);
    chk("rst_tag", 32'(dec_tag_o), 0);
    chk("rst_cls", 32'(cls), 0);

    // ld0 LBU
    rst = 1'b0;
    ld_req_vld_i = 2'b01; ld_req_opcode_i = {3'd0, 3'd3};
    ld_req_tag_i = {8'h00, 8'h11};
    #1 chk("lbu_rdy", 32'(rdy_all), 32'b0001);
    tick();
    chk("lbu_vld", 32'(dec_vld_o), 1);
    chk("lbu_cls", 32'(cls), 32'b100000);
    chk("lbu_size", 32'(dec_size_o), 0);
    chk("lbu_uns", 32'(dec_unsigned_o), 1);
    chk("lbu_src", 32'(dec_src_o), 0);
    chk("lbu_tag", 32'(dec_tag_o), 32'h11);
    ld_req_vld_i = 2'b00;
    tick();
    chk("pop_vld", 32'(dec_vld_o), 0);

    // all four valid, rr_ptr starts at 1
    ld_req_vld_i = 2'b11; ld_req_opcode_i = {3'd2, 3'd0};
    ld_req_tag_i = {8'hA1, 8'hA0};
    st_req_vld_i = 1'b1; st_req_opcode_i = 5'd3; st_req_tag_i = 8'hA2;
    ptw_req_vld_i = 1'b1; ptw_req_tag_i = 8'hA3;
    for (int c = 0; c < 5; c++) begin
      #1 chk("rr_rdy", 32'(rdy_all), 32'd1 << order[c]);
      tick();
      chk("rr_vld", 32'(dec_vld_o), 1);
      chk("rr_src", 32'(dec_src_o), 32'(order[c]));
      chk("rr_tag", 32'(dec_tag_o), 32'hA0 + 32'(order[c]));
    end
    ld_req_vld_i = 2'b00; ptw_req_vld_i = 1'b0;

    // AMOMAXU.D, rr_ptr=2
    st_req_opcode_i = 5'd24; st_req_tag_i = 8'h24;
    #1 chk("amo_rdy", 32'(rdy_all), 32'b0100);
    tick();
    chk("amo_cls", 32'(cls), 32'b000001);
    chk("amo_op", 32'(dec_amo_op_o), 5);
    chk("amo_uns", 32'(dec_unsigned_o), 1);
    chk("amo_size", 32'(dec_size_o), 3);
    chk("amo_src", 32'(dec_src_o), 2);
    st_req_vld_i = 1'b0;
    tick();

    // stall with ld1 pending, rr_ptr=3
    dec_rdy_i = 1'b0;
    ld_req_vld_i = 2'b10; ld_req_opcode_i = {3'd2, 3'd0};
    ld_req_tag_i = {8'h51, 8'h00};
    #1 chk("stall_rdy0", 32'(rdy_all), 32'b0010);
    tick();
    chk("stall_src", 32'(dec_src_o), 1);
    chk("stall_tag0", 32'(dec_tag_o), 32'h51);
    ld_req_opcode_i = {3'd6, 3'd0}; ld_req_tag_i = {8'h52, 8'h00};
    for (int c = 0; c < 3; c++) begin
      #1 chk("stall_rdy", 32'(rdy_all), 0);
      tick();
      chk("stall_vld", 32'(dec_vld_o), 1);
      chk("stall_tag", 32'(dec_tag_o), 32'h51);
      chk("stall_size", 32'(dec_size_o), 2);
    end
    dec_rdy_i = 1'b1;
    #1 chk("resume_rdy", 32'(rdy_all), 32'b0010);
    tick();
    chk("resume_tag", 32'(dec_tag_o), 32'h52);
    chk("resume_size", 32'(dec_size_o), 3);
    chk("resume_src", 32'(dec_src_o), 1);
    ld_req_vld_i = 2'b00;

    // flush with entry valid and PTW pending, rr_ptr=2
    flush_i = 1'b1; dec_rdy_i = 1'b0;
    ptw_req_vld_i = 1'b1; ptw_req_tag_i = 8'h77;
    #1 chk("flush_rdy", 32'(rdy_all), 0);
    tick();
    chk("flush_vld", 32'(dec_vld_o), 0);
    flush_i = 1'b0;
    #1 chk("ptw_rdy", 32'(rdy_all), 32'b1000);
    tick();
    chk("ptw_vld", 32'(dec_vld_o), 1);
    chk("ptw_src", 32'(dec_src_o), 3);
    chk("ptw_size", 32'(dec_size_o), 3);
    chk("ptw_cls", 32'(cls), 32'b001000);
    chk("ptw_tag", 32'(dec_tag_o), 32'h77);
    ptw_req_vld_i = 1'b0;

    // illegal store opcode, rr_ptr=0
    dec_rdy_i = 1'b1;
    st_req_vld_i = 1'b1; st_req_opcode_i = 5'd30; st_req_tag_i = 8'h30;
    #1 chk("ill_rdy", 32'(rdy_all), 32'b0100);
    tick();
    chk("ill_flag", 32'(dec_illegal_o), 1);
    chk("ill_cls", 32'(cls), 0);
    chk("ill_amo", 32'(dec_amo_op_o), 0);
    chk("ill_uns", 32'(dec_unsigned_o), 0);
    chk("ill_size", 32'(dec_size_o), 0);
    chk("ill_src", 32'(dec_src_o), 2);
    st_req_vld_i = 1'b0;

    // rr_ptr=3 now: PTW beats ld0
    ld_req_vld_i = 2'b01; ptw_req_vld_i = 1'b1; ptw_req_tag_i = 8'h88;
    #1 chk("adv_rdy", 32'(rdy_all), 32'b1000);
    tick();
    chk("adv_src", 32'(dec_src_o), 3);
    chk("adv_ill", 32'(dec_illegal_o), 0);
    ld_req_vld_i = 2'b00; ptw_req_vld_i = 1'b0;

    // illegal load opcode on ld1, rr_ptr wrapped to 0
    ld_req_vld_i = 2'b10; ld_req_opcode_i = {3'd7, 3'd0};
    ld_req_tag_i = {8'h99, 8'h00};
    #1 chk("ldill_rdy", 32'(rdy_all), 32'b0010);
    tick();
    chk("ldill_flag", 32'(dec_illegal_o), 1);
    chk("ldill_cls", 32'(cls), 0);
    chk("ldill_src", 32'(dec_src_o), 1);
    ld_req_vld_i = 2'b00;

    // reset during a stall drops the entry
    dec_rdy_i = 1'b0;
    chk("pre_rst_vld", 32'(dec_vld_o), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_vld", 32'(dec_vld_o), 0);
    chk("mid_rst_src", 32'(dec_src_o), 0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
